// File: rtl/screen_sequencer_pkg.sv
// Shared screen codes and player count for the sequencer, end-game and display logic.
// Also holds the priority helper used to pick a single winner.
package screen_sequencer_pkg;

    localparam int NUM_PLAYERS = 4;

    localparam logic [1:0] SCREEN_WELCOME   = 2'b00;
    localparam logic [1:0] SCREEN_COUNTDOWN = 2'b11;
    localparam logic [1:0] SCREEN_GAME      = 2'b01;
    localparam logic [1:0] SCREEN_END       = 2'b10;

    typedef enum logic [1:0] {
        ST_WELCOME   = SCREEN_WELCOME,
        ST_COUNTDOWN = SCREEN_COUNTDOWN,
        ST_GAME      = SCREEN_GAME,
        ST_END       = SCREEN_END
    } screen_e;

    // Keeps only the lowest set bit, so player 0 wins a tie.
    function automatic logic [NUM_PLAYERS-1:0] lowest_onehot(input logic [NUM_PLAYERS-1:0] v);
        return v & (~v + NUM_PLAYERS'(1));
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Player-facing bus of the screen sequencer: button/finish/reset-request inputs
// and the registered screen, winner, countdown and game-start outputs.
interface screen_sequencer_if;
    import screen_sequencer_pkg::*;

    logic [NUM_PLAYERS-1:0] btn_player;
    logic [NUM_PLAYERS-1:0] player_finished;
    logic                   trigger_reset_all;
    logic [1:0]             current_screen;
    logic [NUM_PLAYERS-1:0] winner;
    logic [1:0]             countdown_step;
    logic                   game_started;

    modport master (
        output btn_player, player_finished, trigger_reset_all,
        input  current_screen, winner, countdown_step, game_started
    );

    modport slave (
        input  btn_player, player_finished, trigger_reset_all,
        output current_screen, winner, countdown_step, game_started
    );

endinterface

// File: rtl/screen_sequencer_button_edge_detect.sv
// Rising-edge detector for the player buttons; the history register resets to
// all ones so a button held through reset is not seen as a press.
module button_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] btn_prev;

    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // only seen on a rising edge, never as an asynchronous sensitivity.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= '1;
        end else begin
            btn_prev <= btn;
        end
    end

    assign press = btn & ~btn_prev;

endmodule

// File: rtl/screen_sequencer.sv
// Screen state machine: WELCOME -> (COUNTDOWN) -> GAME -> END -> WELCOME.
// Define SCREEN_COUNTDOWN_EN to include the 3-2-1 countdown screen and its counter.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int COUNTDOWN_CLK_COUNT = 1
) (
    input  logic               clk,
    input  logic               reset,
    screen_sequencer_if.slave  bus
);

    logic [NUM_PLAYERS-1:0] press;
    screen_e                state;
    logic [NUM_PLAYERS-1:0] winner_q;
    logic                   game_started_q;

    button_edge_detect #(.WIDTH(NUM_PLAYERS)) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_player),
        .press (press)
    );

`ifdef SCREEN_COUNTDOWN_EN
    localparam int CNT_W = (COUNTDOWN_CLK_COUNT > 1) ? $clog2(COUNTDOWN_CLK_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTDOWN_CLK_COUNT - 1);

    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       step_q;
`endif

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_WELCOME;
            winner_q       <= '0;
            game_started_q <= 1'b0;
`ifdef SCREEN_COUNTDOWN_EN
            step_cnt       <= '0;
            step_q         <= 2'd0;
`endif
        end else begin
            game_started_q <= 1'b0;
            case (state)
                ST_WELCOME: begin
                    if (|press) begin
`ifdef SCREEN_COUNTDOWN_EN
                        state    <= ST_COUNTDOWN;
                        step_q   <= 2'd3;
                        step_cnt <= '0;
`else
                        state          <= ST_GAME;
                        game_started_q <= 1'b1;
`endif
                    end
                end
`ifdef SCREEN_COUNTDOWN_EN
                ST_COUNTDOWN: begin
                    // Each step value holds for a full COUNTDOWN_CLK_COUNT cycles.
                    if (step_cnt == CNT_LAST) begin
                        step_cnt <= '0;
                        if (step_q == 2'd1) begin
                            state          <= ST_GAME;
                            step_q         <= 2'd0;
                            game_started_q <= 1'b1;
                        end else begin
                            step_q <= step_q - 2'd1;
                        end
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_GAME: begin
                    if (|bus.player_finished) begin
                        winner_q <= lowest_onehot(bus.player_finished);
                        state    <= ST_END;
                    end
                end
                ST_END: begin
                    if (bus.trigger_reset_all) begin
                        winner_q <= '0;
                        state    <= ST_WELCOME;
                    end
                end
                default: begin
                    state <= ST_WELCOME;
                end
            endcase
        end
    end

    assign bus.current_screen = state;
    assign bus.winner         = winner_q;
    assign bus.game_started   = game_started_q;
`ifdef SCREEN_COUNTDOWN_EN
    assign bus.countdown_step = step_q;
`else
    assign bus.countdown_step = 2'd0;
`endif

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter COUNTDOWN_CLK_COUNT, default 1: clock cycles per countdown step, legal range >= 1.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_player  input  4  per-player button level, already synchronized, active-high.
REQ-005 player_finished  input  4  per-player level from race logic, high while that player sits on the finish LED.
REQ-006 trigger_reset_all  input  1  single-cycle pulse from end-game logic requesting return to welcome.
REQ-007 current_screen  output  2  registered screen code: 00 WELCOME, 11 COUNTDOWN, 01 GAME, 10 END.
REQ-008 winner  output  4  registered one-hot winning player, 0000 when no winner.
REQ-009 countdown_step  output  2  registered remaining step: 3, 2, 1 during COUNTDOWN, else 0.
REQ-010 game_started  output  1  registered one-cycle pulse marking entry into GAME.

Function
REQ-011 Button press SHALL mean a rising edge: btn_player bit high now, low in the previous cycle.
REQ-012 WELCOME: any press SHALL move current_screen to COUNTDOWN on the next edge with countdown_step=3.
REQ-013 COUNTDOWN: countdown_step SHALL hold each value exactly COUNTDOWN_CLK_COUNT cycles, then decrement.
REQ-014 After step 1 has held its full count, next edge SHALL give current_screen=GAME, countdown_step=0, game_started=1 for that one cycle.
REQ-015 Total residency in COUNTDOWN SHALL be exactly 3*COUNTDOWN_CLK_COUNT cycles.
REQ-016 Button presses SHALL be ignored in COUNTDOWN, GAME and END.
REQ-017 GAME: any player_finished bit high SHALL, on the next edge, latch winner and set current_screen=END.
REQ-018 Simultaneous finishes SHALL resolve to lowest index (player 0 highest priority); winner always exactly one-hot or zero.
REQ-019 END: winner SHALL hold; player_finished ignored.
REQ-020 END with trigger_reset_all=1 SHALL, on the next edge, set current_screen=WELCOME and winner=0000.
REQ-021 trigger_reset_all SHALL be ignored outside END.
REQ-022 A press coinciding with the END->WELCOME transition SHALL NOT start a countdown; only presses sampled while current_screen=WELCOME count.
REQ-023 Encoding 11 SHALL never appear on current_screen when countdown is compiled out.

Reset
REQ-024 reset SHALL override all other inputs in the same cycle, including mid-countdown and mid-END.
REQ-025 Reset values: current_screen=00, winner=0000, countdown_step=0, game_started=0, step counter=0.
REQ-026 Previous-button register SHALL reset to 1111 so buttons held through reset produce no press.

Configuration
REQ-027 Macro SCREEN_COUNTDOWN_EN defined: COUNTDOWN state, counter and countdown_step behave per REQ-012..015.
REQ-028 Macro undefined: WELCOME press goes directly to GAME with game_started=1 next edge; countdown_step tied to 0; no counter logic synthesized; COUNTDOWN_CLK_COUNT unused.

Structure
REQ-029 Shared package SHALL hold the four screen-code localparams and the player-count constant (4); end-game and display logic import the same codes.
REQ-030 One sub-module, button_edge_detect (4-bit previous register plus rising-edge mask, reset-to-ones), SHALL be instantiated; the state machine and counter live in screen_sequencer.

Verification
REQ-031 COUNTDOWN_CLK_COUNT=2, macro on: reset, press btn_player=0001 -> screen 11, step 3,3,2,2,1,1, then screen 01 with game_started high one cycle.
REQ-032 In GAME drive player_finished=0110 -> next edge winner=0010, screen 10; later finished=1000 -> winner unchanged.
REQ-033 In END pulse trigger_reset_all -> next edge screen 00, winner 0000; pulse in GAME -> no effect.
REQ-034 Hold btn_player=1111 through reset release -> stays WELCOME; release then press bit 2 -> COUNTDOWN.
REQ-035 Assert reset during step 2 of COUNTDOWN -> next edge all outputs at reset values.
REQ-036 Macro off: press in WELCOME -> next edge screen 01, game_started=1, countdown_step=0; screen never 11.
